mem_access: RTL and testbench

- MEM pipeline stage placed directly downstream of EX.
- Latches EX results (write-back register info, HI/LO update, ALU op, RAM address, store data) and runs the data-bus transaction for LB/LW/SB/SW through a req/ack FSM.
- Forwards register and HI/LO results to WB and back to EX for forwarding.
- Raises a stall request while a bus access is outstanding.

---
 rtl/mem_access.sv | 156 +++++++++++++++
 tb/tb_mem_access.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// MEM pipeline stage: latches EX results, runs the LB/LW/SB/SW data-bus handshake
// and forwards register and HI/LO results to WB and EX. ex_alu_i is an 8-bit opcode.
module mem_access #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned REG_ADDR_W  = 5,
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         stall_i,
  input  logic                         flush_i,
  input  logic [REG_ADDR_W+DATA_W:0]   ex_wreg_i,
  input  logic [2*DATA_W:0]            ex_hilo_i,
  input  logic [7:0]                   ex_alu_i,
  input  logic [DATA_W-1:0]            ex_ramaddr_i,
  input  logic [DATA_W-1:0]            ex_storedata_i,
  input  logic [DATA_W-1:0]            ram_rdata_i,
  input  logic                         ram_ack_i,
  output logic                         ram_req_o,
  output logic                         ram_we_o,
  output logic [DATA_W-1:0]            ram_addr_o,
  output logic [3:0]                   ram_sel_o,
  output logic [DATA_W-1:0]            ram_wdata_o,
  output logic [REG_ADDR_W+DATA_W:0]   mem_wreg_o,
  output logic [2*DATA_W:0]            mem_hilo_o,
  output logic                         stallreq_from_mem,
  output logic                         mem_err_o
);

  localparam int unsigned WREG_W = 1 + REG_ADDR_W + DATA_W;
  localparam int unsigned HILO_W = 1 + 2 * DATA_W;
  localparam int unsigned CNT_W  = $clog2(ACK_TIMEOUT + 1);

  localparam logic [7:0] OP_NOP = 8'h00;
  localparam logic [7:0] OP_LB  = 8'h20;
  localparam logic [7:0] OP_LW  = 8'h23;
  localparam logic [7:0] OP_SB  = 8'h28;
  localparam logic [7:0] OP_SW  = 8'h2B;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

  state_t              state, state_d;
  logic [WREG_W-1:0]   wreg_q;
  logic [HILO_W-1:0]   hilo_q;
  logic [7:0]          op_q;
  logic [DATA_W-1:0]   addr_q, sdata_q, rdata_q;
  logic                valid_q, err_q;
  logic [CNT_W-1:0]    cnt_q;

  logic                capture, in_is_mem, timeout_hit;
  logic                is_load, is_store, wreg_en;
  logic [1:0]          k;
  logic [7:0]          lbyte;
  logic [3:0]          lane;
  logic [DATA_W-1:0]   load_data;

  assign in_is_mem = (ex_alu_i == OP_LB) || (ex_alu_i == OP_LW) ||
                     (ex_alu_i == OP_SB) || (ex_alu_i == OP_SW);

  always_comb begin
    capture     = !flush_i && (state != S_REQ) && !stall_i;
    timeout_hit = (state == S_REQ) && !ram_ack_i && (cnt_q == CNT_W'(ACK_TIMEOUT - 1));
    state_d     = state;
    case (state)
      S_IDLE:  if (capture && in_is_mem) state_d = S_REQ;
      S_REQ:   if (ram_ack_i || timeout_hit) state_d = S_DONE;
      S_DONE:  state_d = (capture && in_is_mem) ? S_REQ : S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush_i) state_d = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      wreg_q  <= '0;
      hilo_q  <= '0;
      op_q    <= OP_NOP;
      addr_q  <= '0;
      sdata_q <= '0;
      rdata_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state <= state_d;
      err_q <= timeout_hit && !flush_i;
      if (state == S_REQ && !ram_ack_i && !timeout_hit && !flush_i)
        cnt_q <= cnt_q + CNT_W'(1);
      else
        cnt_q <= '0;
      // An abandoned load must read back as zero, not stale bus data.
      if (state == S_REQ) begin
        if (ram_ack_i)        rdata_q <= ram_rdata_i;
        else if (timeout_hit) rdata_q <= '0;
      end
      if (flush_i) begin
        wreg_q  <= '0;
        hilo_q  <= '0;
        op_q    <= OP_NOP;
        valid_q <= 1'b0;
      end else if (state == S_REQ) begin
        valid_q <= valid_q;
      end else if (!stall_i) begin
        wreg_q  <= ex_wreg_i;
        hilo_q  <= ex_hilo_i;
        op_q    <= ex_alu_i;
        addr_q  <= ex_ramaddr_i;
        sdata_q <= ex_storedata_i;
        valid_q <= 1'b1;
      end else begin
        valid_q <= 1'b0;
      end
    end
  end

  always_comb begin
    is_load  = (op_q == OP_LB) || (op_q == OP_LW);
    is_store = (op_q == OP_SB) || (op_q == OP_SW);
    k        = addr_q[1:0];
    lane     = 4'b1000 >> k;
    // Big-endian: byte offset 0 lives in the most significant lane.
    case (k)
      2'd0:    lbyte = rdata_q[31:24];
      2'd1:    lbyte = rdata_q[23:16];
      2'd2:    lbyte = rdata_q[15:8];
      default: lbyte = rdata_q[7:0];
    endcase
    load_data = (op_q == OP_LB) ? {{(DATA_W-8){lbyte[7]}}, lbyte} : rdata_q;

    ram_req_o   = (state == S_REQ);
    ram_we_o    = ram_req_o && is_store;
    ram_addr_o  = ram_req_o ? {addr_q[DATA_W-1:2], 2'b00} : '0;
    ram_sel_o   = '0;
    ram_wdata_o = '0;
    if (ram_req_o) begin
      ram_sel_o = ((op_q == OP_LB) || (op_q == OP_SB)) ? lane : 4'b1111;
      if (op_q == OP_SB)      ram_wdata_o = {(DATA_W/8){sdata_q[7:0]}};
      else if (op_q == OP_SW) ram_wdata_o = sdata_q;
    end

    wreg_en    = wreg_q[WREG_W-1] & valid_q;
    mem_wreg_o = {wreg_en, wreg_q[WREG_W-2:0]};
    if (is_store) begin
      mem_wreg_o[WREG_W-1] = 1'b0;
    end else if (is_load) begin
      if (state == S_DONE) mem_wreg_o = {wreg_en, wreg_q[WREG_W-2:DATA_W], load_data};
      else                 mem_wreg_o[WREG_W-1] = 1'b0;
    end

    mem_hilo_o        = {hilo_q[HILO_W-1] & valid_q, hilo_q[HILO_W-2:0]};
    stallreq_from_mem = (state == S_REQ);
    mem_err_o         = err_q;
  end

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: stimulus pushes expected bus requests and
// write-backs; a negedge monitor pops and compares whenever the DUT presents them.
module tb_mem_access;

  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_ADD  = 8'h01;
  localparam logic [7:0] OP_MTHI = 8'h11;
  localparam logic [7:0] OP_LB   = 8'h20;
  localparam logic [7:0] OP_LW   = 8'h23;
  localparam logic [7:0] OP_SB   = 8'h28;
  localparam logic [7:0] OP_SW   = 8'h2B;

  logic        clk = 1'b0;
  logic        rst, stall_i, flush_i;
  logic [37:0] ex_wreg_i;
  logic [64:0] ex_hilo_i;
  logic [7:0]  ex_alu_i;
  logic [31:0] ex_ramaddr_i, ex_storedata_i, ram_rdata_i;
  logic        ram_ack_i;
  logic        ram_req_o, ram_we_o;
  logic [31:0] ram_addr_o, ram_wdata_o;
  logic [3:0]  ram_sel_o;
  logic [37:0] mem_wreg_o;
  logic [64:0] mem_hilo_o;
  logic        stallreq_from_mem, mem_err_o;

  mem_access #(.DATA_W(32), .REG_ADDR_W(5), .ACK_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
    .ex_wreg_i(ex_wreg_i), .ex_hilo_i(ex_hilo_i), .ex_alu_i(ex_alu_i),
    .ex_ramaddr_i(ex_ramaddr_i), .ex_storedata_i(ex_storedata_i),
    .ram_rdata_i(ram_rdata_i), .ram_ack_i(ram_ack_i),
    .ram_req_o(ram_req_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
    .ram_sel_o(ram_sel_o), .ram_wdata_o(ram_wdata_o),
    .mem_wreg_o(mem_wreg_o), .mem_hilo_o(mem_hilo_o),
    .stallreq_from_mem(stallreq_from_mem), .mem_err_o(mem_err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
    int unsigned len;
  } bus_t;

  typedef struct {
    logic [7:0]  op;
    logic [4:0]  rt;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] rdata;
    int unsigned delay;
    logic [31:0] exp_addr;
    logic [3:0]  exp_sel;
    logic [31:0] exp_wdata;
    logic [31:0] exp_ldata;
  } vec_t;

  bus_t        bus_q[$];
  logic [37:0] wb_q[$];
  logic [64:0] hilo_q[$];
  int unsigned checks = 0, failures = 0;
  int unsigned err_seen = 0, exp_err = 0;
  bit          mon_en = 1'b0;
  vec_t        vecs[7];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    failures++;
    $display("FAIL %s: got output with no pending expectation, expected none", name);
  endtask

  function automatic logic [255:0] all_outs();
    return 256'({ram_req_o, ram_we_o, ram_addr_o, ram_sel_o, ram_wdata_o,
                 mem_wreg_o, mem_hilo_o, stallreq_from_mem, mem_err_o});
  endfunction

  task automatic drive_nop();
    ex_alu_i       = OP_NOP;
    ex_wreg_i      = '0;
    ex_hilo_i      = '0;
    ex_ramaddr_i   = '0;
    ex_storedata_i = '0;
  endtask

  task automatic issue_mem(input logic [7:0] op, input logic [4:0] rt,
                           input logic [31:0] addr, input logic [31:0] sdata);
    ex_alu_i       = op;
    ex_ramaddr_i   = addr;
    ex_storedata_i = sdata;
    ex_hilo_i      = '0;
    ex_wreg_i      = (op == OP_LB || op == OP_LW) ? {1'b1, rt, 32'h0} : '0;
  endtask

  task automatic mem_op(input vec_t v);
    bus_t b;
    bit   ld;
    ld      = (v.op == OP_LB) || (v.op == OP_LW);
    b.we    = !ld;
    b.addr  = v.exp_addr;
    b.sel   = v.exp_sel;
    b.wdata = v.exp_wdata;
    b.len   = v.delay + 1;
    bus_q.push_back(b);
    if (ld) wb_q.push_back({1'b1, v.rt, v.exp_ldata});
    issue_mem(v.op, v.rt, v.addr, v.sdata);
    @(posedge clk); #1;
    drive_nop();
    repeat (v.delay) begin
      chk("stallreq_in_req", 256'(stallreq_from_mem), 256'(1));
      @(posedge clk); #1;
    end
    chk("stallreq_in_req", 256'(stallreq_from_mem), 256'(1));
    ram_ack_i   = 1'b1;
    ram_rdata_i = v.rdata;
    @(posedge clk); #1;
    ram_ack_i   = 1'b0;
    ram_rdata_i = '0;
    chk("stall_released", 256'(stallreq_from_mem), 256'(0));
    chk("done_wb_en", 256'(mem_wreg_o[37]), 256'(ld));
    @(posedge clk); #1;
  endtask

  // Monitor: compares every presented bus request, write-back and HI/LO update.
  initial begin
    bus_t        cur;
    bit          in_run;
    int unsigned run_len;
    in_run  = 1'b0;
    run_len = 0;
    cur     = '{default: 0};
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (ram_req_o === 1'b1) begin
          if (!in_run) begin
            in_run  = 1'b1;
            run_len = 0;
            if (bus_q.size() == 0) begin
              unexpected("bus_req");
              cur = '{default: 0};
            end else begin
              cur = bus_q.pop_front();
            end
          end
          run_len++;
          chk("bus_fields", 256'({ram_we_o, ram_addr_o, ram_sel_o, ram_wdata_o}),
              256'({cur.we, cur.addr, cur.sel, cur.wdata}));
        end else begin
          if (in_run) begin
            chk("req_len", 256'(run_len), 256'(cur.len));
            in_run = 1'b0;
          end
          chk("idle_bus", 256'({ram_we_o, ram_sel_o}), 256'(0));
        end
        if (mem_wreg_o[37] === 1'b1) begin
          if (wb_q.size() == 0) unexpected("wb");
          else chk("wb", 256'(mem_wreg_o), 256'(wb_q.pop_front()));
        end
        if (mem_hilo_o[64] === 1'b1) begin
          if (hilo_q.size() == 0) unexpected("hilo");
          else chk("hilo", 256'(mem_hilo_o), 256'(hilo_q.pop_front()));
        end
        if (mem_err_o === 1'b1) err_seen++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{OP_LW, 5'd7, 32'h0000_0104, 32'h0,         32'hDEAD_BEEF, 3, 32'h104, 4'b1111, 32'h0,         32'hDEAD_BEEF};
    vecs[1] = '{OP_LB, 5'd8, 32'h0000_0203, 32'h0,         32'h1234_56F0, 1, 32'h200, 4'b0001, 32'h0,         32'hFFFF_FFF0};
    vecs[2] = '{OP_LB, 5'd8, 32'h0000_0200, 32'h0,         32'h1234_56F0, 0, 32'h200, 4'b1000, 32'h0,         32'h0000_0012};
    vecs[3] = '{OP_LB, 5'd9, 32'h0000_0102, 32'h0,         32'h1234_56F0, 0, 32'h100, 4'b0010, 32'h0,         32'h0000_0056};
    vecs[4] = '{OP_SB, 5'd0, 32'h0000_0101, 32'h0000_00AB, 32'hFFFF_FFFF, 2, 32'h100, 4'b0100, 32'hABAB_ABAB, 32'h0};
    vecs[5] = '{OP_SW, 5'd0, 32'h0000_010E, 32'hCAFE_F00D, 32'hFFFF_FFFF, 0, 32'h10C, 4'b1111, 32'hCAFE_F00D, 32'h0};
    vecs[6] = '{OP_LW, 5'd4, 32'h0000_0107, 32'h0,         32'h0BAD_F00D, 1, 32'h104, 4'b1111, 32'h0,         32'h0BAD_F00D};

    rst = 1'b1; stall_i = 1'b0; flush_i = 1'b0;
    ram_ack_i = 1'b0; ram_rdata_i = '0;
    drive_nop();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", all_outs(), 256'(0));
    rst    = 1'b0;
    mon_en = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) mem_op(vecs[i]);

    // ADD to r3 then a two-cycle stall: exactly one write-back.
    wb_q.push_back({1'b1, 5'd3, 32'h5});
    ex_alu_i  = OP_ADD;
    ex_wreg_i = {1'b1, 5'd3, 32'h5};
    @(posedge clk); #1;
    chk("add_wb_en", 256'(mem_wreg_o[37]), 256'(1));
    stall_i = 1'b1;
    @(posedge clk); #1;
    chk("stall_wb_en", 256'(mem_wreg_o[37]), 256'(0));
    @(posedge clk); #1;
    chk("stall_wb_en", 256'(mem_wreg_o[37]), 256'(0));
    stall_i = 1'b0;
    drive_nop();
    @(posedge clk); #1;

    // HI/LO forwarding with zero added latency.
    hilo_q.push_back({1'b1, 32'h1111_2222, 32'h3333_4444});
    ex_alu_i  = OP_MTHI;
    ex_hilo_i = {1'b1, 32'h1111_2222, 32'h3333_4444};
    @(posedge clk); #1;
    chk("hilo_en", 256'(mem_hilo_o[64]), 256'(1));
    drive_nop();
    @(posedge clk); #1;

    // LW that is never acknowledged: abandoned after 4 REQ cycles.
    bus_q.push_back('{1'b0, 32'h40, 4'b1111, 32'h0, 4});
    wb_q.push_back({1'b1, 5'd9, 32'h0});
    exp_err++;
    issue_mem(OP_LW, 5'd9, 32'h0000_0040, 32'h0);
    @(posedge clk); #1;
    drive_nop();
    repeat (4) @(posedge clk);
    #1;
    chk("timeout_err", 256'(mem_err_o), 256'(1));
    chk("timeout_stall", 256'(stallreq_from_mem), 256'(0));
    @(posedge clk); #1;
    chk("timeout_err_gone", 256'(mem_err_o), 256'(0));
    chk("timeout_idle_req", 256'(ram_req_o), 256'(0));

    // Flush in the second REQ cycle: no write-back, back to IDLE.
    bus_q.push_back('{1'b0, 32'h80, 4'b1111, 32'h0, 2});
    issue_mem(OP_LW, 5'd10, 32'h0000_0080, 32'h0);
    @(posedge clk); #1;
    drive_nop();
    @(posedge clk); #1;
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    chk("flush_req", 256'(ram_req_o), 256'(0));
    chk("flush_stall", 256'(stallreq_from_mem), 256'(0));
    @(posedge clk); #1;

    // Reset during REQ clears every output the next cycle.
    bus_q.push_back('{1'b0, 32'h90, 4'b1111, 32'h0, 1});
    issue_mem(OP_LW, 5'd11, 32'h0000_0090, 32'h0);
    @(posedge clk); #1;
    drive_nop();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_in_req_outputs", all_outs(), 256'(0));
    repeat (3) @(posedge clk);
    #1;

    chk("err_pulses", 256'(err_seen), 256'(exp_err));
    chk("bus_q_drained", 256'(bus_q.size()), 256'(0));
    chk("wb_q_drained", 256'(wb_q.size()), 256'(0));
    chk("hilo_q_drained", 256'(hilo_q.size()), 256'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
